// File: rtl/dpi_pkt_sequencer_pkg.sv
// rtl/dpi_pkt_sequencer_pkg.sv - shared types, defaults and helpers for the packet sequencer
package dpi_pkt_sequencer_pkg;

    localparam int NUM_STREAMS_DEF = 64;
    localparam int KEY_W_DEF       = 16;
    localparam int SID_W           = 6;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_WAIT,
        ST_STREAM,
        ST_EOP,
        ST_DRAIN
    } seq_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dpi_pkt_sequencer_if.sv
// rtl/dpi_pkt_sequencer_if.sv - parser-side stream, regex-side context and statistics bundle
interface dpi_pkt_sequencer_if #(
    parameter int KEY_W = dpi_pkt_sequencer_pkg::KEY_W_DEF
) ();
    import dpi_pkt_sequencer_pkg::*;

    logic [7:0]       in_data;
    logic             in_vld;
    logic             in_sop;
    logic             in_eop;
    logic [KEY_W-1:0] in_flow_key;
    logic             in_rdy;

    logic [7:0]       char_in;
    logic             char_in_vld;
    logic             load_state;
    logic [SID_W-1:0] stream_id;
    logic             new_stream_id;
    logic             enable;
    logic             eop;

    logic             clr_vld;
    logic [SID_W-1:0] clr_id;

    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] untracked_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_data, in_vld, in_sop, in_eop, in_flow_key, clr_vld, clr_id,
        input  in_rdy, char_in, char_in_vld, load_state, stream_id, new_stream_id,
               enable, eop, pkt_cnt, untracked_cnt, err_cnt
    );

    modport slave (
        input  in_data, in_vld, in_sop, in_eop, in_flow_key, clr_vld, clr_id,
        output in_rdy, char_in, char_in_vld, load_state, stream_id, new_stream_id,
               enable, eop, pkt_cnt, untracked_cnt, err_cnt
    );

endinterface

// File: rtl/dpi_flow_table.sv
// rtl/dpi_flow_table.sv - flow key table with parallel match, lowest-free allocation and clear port
module dpi_flow_table
    import dpi_pkt_sequencer_pkg::*;
#(
    parameter int NUM_STREAMS = NUM_STREAMS_DEF,
    parameter int KEY_W       = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_i,
    input  logic             alloc_i,
    input  logic             clr_vld_i,
    input  logic [SID_W-1:0] clr_id_i,
    output logic             hit_o,
    output logic [SID_W-1:0] hit_idx_o,
    output logic             free_o,
    output logic [SID_W-1:0] free_idx_o
);

    logic [KEY_W-1:0]       key_q [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q;
    logic                   hit;
    logic                   free;
    logic [SID_W-1:0]       hit_idx;
    logic [SID_W-1:0]       free_idx;

    // Scanning downwards lets the lowest matching/free index be the final assignment.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == key_i)) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = SID_W'(i);
            end
        end
    end

    // The allocation write comes last so it overrides a same-index clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_vld_i) begin
                valid_q[clr_id_i] <= 1'b0;
            end
            if (alloc_i) begin
                valid_q[free_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i) begin
            key_q[free_idx] <= key_i;
        end
    end

    assign hit_o      = hit;
    assign hit_idx_o  = hit_idx;
    assign free_o     = free;
    assign free_idx_o = free_idx;

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// rtl/dpi_pkt_sequencer.sv - assigns flow contexts to packets and serialises bytes to the regex wrappers
module dpi_pkt_sequencer
    import dpi_pkt_sequencer_pkg::*;
#(
    parameter int NUM_STREAMS = NUM_STREAMS_DEF,
    parameter int KEY_W       = KEY_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dpi_pkt_sequencer_if.slave seq_if
);

    seq_state_e       state_q, state_d;
    logic             rdy_en_q;
    logic             last_q;
    logic [7:0]       sop_byte_q;
    logic [KEY_W-1:0] key_q;
    logic [7:0]       char_q;
    logic             char_vld_q;
    logic [SID_W-1:0] sid_q;
    logic             new_q;
    logic             en_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] untracked_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             rdy;
    logic             accept;
    logic             load_pulse;
    logic             eop_pulse;
    logic             hit;
    logic             free_avail;
    logic             alloc;
    logic [SID_W-1:0] hit_idx;
    logic [SID_W-1:0] free_idx;

    dpi_flow_table #(
        .NUM_STREAMS (NUM_STREAMS),
        .KEY_W       (KEY_W)
    ) u_flow_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_i      (key_q),
        .alloc_i    (alloc),
        .clr_vld_i  (seq_if.clr_vld),
        .clr_id_i   (seq_if.clr_id),
        .hit_o      (hit),
        .hit_idx_o  (hit_idx),
        .free_o     (free_avail),
        .free_idx_o (free_idx)
    );

    assign alloc  = (state_q == ST_LOOKUP) && !hit && free_avail;
    assign accept = seq_if.in_vld && rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STREAM stops accepting once the eop byte is in, then leaves after that byte is shown.
    always_comb begin
        state_d    = state_q;
        rdy        = 1'b0;
        load_pulse = 1'b0;
        eop_pulse  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = rdy_en_q;
                if (seq_if.in_vld && rdy_en_q && seq_if.in_sop) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_LOAD;
            ST_LOAD: begin
                load_pulse = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT:   state_d = ST_STREAM;
            ST_STREAM: begin
                rdy = !last_q;
                if (last_q) begin
                    state_d = ST_EOP;
                end
            end
            ST_EOP: begin
                eop_pulse = 1'b1;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q        <= 1'b0;
            last_q          <= 1'b0;
            sop_byte_q      <= '0;
            key_q           <= '0;
            char_q          <= '0;
            char_vld_q      <= 1'b0;
            sid_q           <= '0;
            new_q           <= 1'b0;
            en_q            <= 1'b0;
            pkt_cnt_q       <= '0;
            untracked_cnt_q <= '0;
            err_cnt_q       <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            char_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (seq_if.in_sop) begin
                            sop_byte_q <= seq_if.in_data;
                            key_q      <= seq_if.in_flow_key;
                            last_q     <= seq_if.in_eop;
                        end else begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        sid_q <= hit_idx;
                        new_q <= 1'b0;
                        en_q  <= 1'b1;
                    end else if (free_avail) begin
                        sid_q <= free_idx;
                        new_q <= 1'b1;
                        en_q  <= 1'b1;
                    end else begin
                        sid_q           <= '0;
                        new_q           <= 1'b1;
                        en_q            <= 1'b0;
                        untracked_cnt_q <= sat_inc(untracked_cnt_q);
                    end
                end
                ST_WAIT: begin
                    char_q     <= sop_byte_q;
                    char_vld_q <= 1'b1;
                end
                ST_STREAM: begin
                    if (accept) begin
                        char_q     <= seq_if.in_data;
                        char_vld_q <= 1'b1;
                        last_q     <= seq_if.in_eop;
                        if (seq_if.in_sop) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                    end
                end
                ST_EOP: pkt_cnt_q <= sat_inc(pkt_cnt_q);
                default: ;
            endcase
        end
    end

    assign seq_if.in_rdy        = rdy;
    assign seq_if.char_in       = char_q;
    assign seq_if.char_in_vld   = char_vld_q;
    assign seq_if.load_state    = load_pulse;
    assign seq_if.eop           = eop_pulse;
    assign seq_if.stream_id     = sid_q;
    assign seq_if.new_stream_id = new_q;
    assign seq_if.enable        = en_q;
    assign seq_if.pkt_cnt       = pkt_cnt_q;
    assign seq_if.untracked_cnt = untracked_cnt_q;
    assign seq_if.err_cnt       = err_cnt_q;

endmodule

// File: doc/dpi_pkt_sequencer.md
DPI_PKT_SEQUENCER -- requirements
Module: dpi_pkt_sequencer

Interface
REQ-001 Parameter NUM_STREAMS, default 64, number of flow-table entries; stream_id width is 6.
REQ-002 Parameter KEY_W, default 16, flow key width.
REQ-003 clk  input  1  single clock; every register samples on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  8  packet byte from the upstream parser.
REQ-006 in_vld  input  1  in_data valid; a beat transfers when in_vld and in_rdy are both 1.
REQ-007 in_sop / in_eop  input  1 each  first / last byte of a packet; both may be 1 on the same beat.
REQ-008 in_flow_key  input  KEY_W  flow key, sampled only on the sop beat.
REQ-009 in_rdy  output  1  beat acceptance.
REQ-010 char_in / char_in_vld  output  8 / 1  byte to the regex wrappers, plus its valid.
REQ-011 load_state  output  1  one-cycle pulse requesting a per-stream state restore.
REQ-012 stream_id / new_stream_id / enable  output  6 / 1 / 1  stream context for the current packet.
REQ-013 eop  output  1  one-cycle end-of-packet pulse to the wrappers.
REQ-014 clr_vld / clr_id  input  1 / 6  frees one flow-table entry.
REQ-015 pkt_cnt / untracked_cnt / err_cnt  output  16 each  saturating statistics.

Function
REQ-016 FSM states IDLE, LOOKUP, LOAD, WAIT, STREAM, EOP, DRAIN; in_rdy SHALL be 1 only in IDLE and STREAM.
REQ-017 In IDLE, an accepted sop beat SHALL latch in_data and in_flow_key and move the FSM to LOOKUP; the beat's in_eop SHALL be latched as last.
REQ-018 In IDLE, an accepted beat with in_sop=0 SHALL be discarded, increment err_cnt, and leave the FSM in IDLE.
REQ-019 In LOOKUP, the FSM SHALL compare the key against all valid entries in a single cycle. Outcomes: on a hit, stream_id=index, new_stream_id=0, enable=1; on a miss with a free entry, allocate the lowest free index, store the key, and drive new_stream_id=1, enable=1; on a miss with the table full, drive stream_id=0, new_stream_id=1, enable=0 and increment untracked_cnt.
REQ-020 In LOAD, load_state SHALL be 1 for exactly one cycle; stream_id, new_stream_id and enable SHALL be valid from LOAD and held stable through the EOP cycle.
REQ-021 WAIT SHALL last one cycle. The first char_in_vld SHALL come exactly 2 cycles after load_state, carrying the latched sop byte.
REQ-022 In STREAM, each accepted byte SHALL appear on char_in with char_in_vld=1 exactly 1 cycle after acceptance; byte order SHALL be preserved.
REQ-023 The eop output SHALL pulse exactly 1 cycle after the char_in_vld of the last byte, with char_in_vld=0 in that cycle.
REQ-024 DRAIN SHALL last one cycle with in_rdy=0, so that eop and the next load_state are never adjacent.
REQ-025 pkt_cnt SHALL increment in the EOP cycle.
REQ-026 A single-byte packet SHALL follow this timing: sop at t, load_state at t+2, char_in_vld at t+4, eop at t+5, in_rdy=1 again at t+7.
REQ-027 An accepted in_sop=1 beat in STREAM SHALL be passed through as data, with sop ignored and err_cnt incremented.
REQ-028 clr_vld SHALL invalidate entry clr_id on the next edge. If it coincides with a LOOKUP allocation of the same index, the allocation SHALL win and the clear SHALL be dropped. Clearing the active stream's entry SHALL NOT alter the packet in flight.
REQ-029 All statistics counters SHALL saturate at 16'hFFFF.
REQ-030 char_in_vld, load_state and eop SHALL be mutually exclusive in every cycle.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously return to IDLE, invalidate all flow entries, and clear every counter.
REQ-032 While rst_n=0, all outputs SHALL be 0 and in_rdy SHALL be 0.
REQ-033 If reset is asserted mid-packet, the packet SHALL be abandoned with no eop emitted.
REQ-034 in_rdy SHALL first be 1 in the cycle after rst_n deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the NUM_STREAMS and KEY_W defaults, and the stream_id width constant.
REQ-036 The flow table SHALL be one sub-module, dpi_flow_table: key/valid storage, parallel compare, lowest-free priority encoder, and clear port.

Verification
REQ-037 After reset, send key 16'h1234 with 3 bytes 41,42,43: load_state at t+2 with stream_id=0, new_stream_id=1, enable=1; chars at t+4..t+6; eop at t+7; pkt_cnt=1.
REQ-038 Repeat key 16'h1234: stream_id=0, new_stream_id=0.
REQ-039 Fill 64 distinct keys, then send a 65th: enable=0, untracked_cnt=1, stream_id=0, new_stream_id=1.
REQ-040 Issue clr_id=5 with table full, then send a new key: stream_id=5, new_stream_id=1.
REQ-041 Send a non-sop beat in IDLE, then a sop beat mid-packet: err_cnt=2, and the packet is still delivered intact.
REQ-042 Assert rst_n=0 mid-STREAM: outputs are 0 immediately, no eop is emitted, and the next packet with key 16'h1234 gives new_stream_id=1.
